// File: rtl/moldudp64_seq_ctrl_if.sv
// Bus bundle for the MoldUDP64 sequencing controller: UDP payload stream in,
// dispatcher beats out, and the retransmit request handshake.
//
// Retransmit handshake: rtx_valid_o rises with a request and stays high with
// rtx_seq_o/rtx_cnt_o stable-or-merging until the first cycle in which
// rtx_ready_i is also high; that cycle is the transfer. rtx_ready_i may be
// high at any time and has no effect while rtx_valid_o is low.
interface moldudp64_seq_ctrl_if #(
    parameter int AXI_DATA_W = 64,
    parameter int AXI_KEEP_W = AXI_DATA_W / 8,
    parameter int SEQ_W      = 64,
    parameter int CNT_W      = 16
);
    logic                  valid_i;
    logic [AXI_DATA_W-1:0] data_i;
    logic [AXI_KEEP_W-1:0] keep_i;
    logic                  last_i;

    logic                  disp_valid_o;
    logic [AXI_DATA_W-1:0] disp_data_o;
    logic [AXI_KEEP_W-1:0] disp_keep_o;
    logic                  disp_init_v_o;
    logic                  disp_last_o;

    logic                  rtx_valid_o;
    logic                  rtx_ready_i;
    logic [SEQ_W-1:0]      rtx_seq_o;
    logic [CNT_W-1:0]      rtx_cnt_o;

    // Controller side
    modport slave (
        input  valid_i, data_i, keep_i, last_i, rtx_ready_i,
        output disp_valid_o, disp_data_o, disp_keep_o, disp_init_v_o, disp_last_o,
        output rtx_valid_o, rtx_seq_o, rtx_cnt_o
    );

    // Environment side (UDP source, dispatcher, retransmit client)
    modport master (
        output valid_i, data_i, keep_i, last_i, rtx_ready_i,
        input  disp_valid_o, disp_data_o, disp_keep_o, disp_init_v_o, disp_last_o,
        input  rtx_valid_o, rtx_seq_o, rtx_cnt_o
    );
endinterface

// File: rtl/moldudp64_seq_ctrl.sv
// MoldUDP64 sequencing controller. Parses the 20-byte header (beats 0-2 of
// a 64-bit stream), locks onto the first session seen, and forwards only
// in-order packets to the dispatcher. Gaps raise a retransmit request.
// Optional statistics counters are enabled with `define MOLD_SEQ_STATS_EN.
// Only a 64-bit data path (AXI_DATA_W = 64, SEQ_W = 64, CNT_W = 16) is supported.
module moldudp64_seq_ctrl #(
    parameter int AXI_DATA_W = 64,
    parameter int AXI_KEEP_W = AXI_DATA_W / 8,
    parameter int SEQ_W      = 64,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 nreset,
    moldudp64_seq_ctrl_if.slave  bus,
    output logic [SEQ_W-1:0]     exp_seq_o,
    output logic                 sess_lock_o,
    output logic                 eos_o,
    output logic                 drop_o,
    output logic                 err_o,
    output logic [2:0]           state_o
`ifdef MOLD_SEQ_STATS_EN
    ,
    output logic [31:0]          stat_acc_o,
    output logic [31:0]          stat_drop_o,
    output logic [31:0]          stat_gap_o
`endif
);

    typedef enum logic [2:0] {
        H0   = 3'd0,
        H1   = 3'd1,
        H2   = 3'd2,
        FWD  = 3'd3,
        DROP = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Byte k of a beat sits at data[8k+7:8k]; header fields are big-endian,
    // so reverse the bytes to get packet order with byte 0 in the MSBs.
    function automatic logic [63:0] to_be(input logic [63:0] d);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[63-8*k -: 8] = d[8*k +: 8];
        end
        return r;
    endfunction

    function automatic logic [15:0] sat16(input logic [63:0] d);
        return (d > 64'h0000_0000_0000_FFFF) ? 16'hFFFF : d[15:0];
    endfunction

    // Header capture and locked session
    logic [63:0]      sess_hi_q;   // session bytes 0-7
    logic [15:0]      sess_lo_q;   // session bytes 8-9
    logic [47:0]      seq_hi_q;    // seq bytes 10-15
    logic [79:0]      sess_q;      // locked session
    logic             sess_lock_q;
    logic [SEQ_W-1:0] exp_seq_q;
    logic             eos_q;

    // Retransmit request
    logic             rtx_valid_q;
    logic [SEQ_W-1:0] rtx_seq_q;
    logic [CNT_W-1:0] rtx_cnt_q;

    // Dispatcher output register
    logic                  disp_valid_q;
    logic [AXI_DATA_W-1:0] disp_data_q;
    logic [AXI_KEEP_W-1:0] disp_keep_q;
    logic                  disp_init_q;
    logic                  disp_last_q;

    logic drop_q;
    logic err_q;

    // Header fields as seen on the H2 beat
    logic [63:0]      beat_be;
    logic [79:0]      pkt_sess;
    logic [63:0]      pkt_seq;
    logic [15:0]      pkt_cnt;
    logic [SEQ_W-1:0] exp_eff;
    logic             sess_ok;

    assign beat_be  = to_be(bus.data_i);
    assign pkt_sess = {sess_hi_q, sess_lo_q};
    assign pkt_seq  = {seq_hi_q, beat_be[63:48]};
    assign pkt_cnt  = beat_be[47:32];
    // An unlocked controller adopts the packet's seq as the expected value.
    assign exp_eff  = sess_lock_q ? exp_seq_q : pkt_seq;
    assign sess_ok  = !sess_lock_q || (pkt_sess == sess_q);

    // Decision strobes, valid only for the beat being consumed this cycle
    logic short_err;
    logic mismatch;
    logic accept;
    logic reject;
    logic is_eos;
    logic is_dup;
    logic is_gap;
    logic do_lock;
    logic fwd_beat;

    // State register
    always_ff @(posedge clk) begin
        if (!nreset) state_q <= H0;
        else         state_q <= state_d;
    end

    // Next state and per-beat decisions
    always_comb begin
        state_d   = state_q;
        short_err = 1'b0;
        mismatch  = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        is_eos    = 1'b0;
        is_dup    = 1'b0;
        is_gap    = 1'b0;
        do_lock   = 1'b0;
        fwd_beat  = 1'b0;
        if (bus.valid_i) begin
            case (state_q)
                H0: begin
                    if (bus.last_i) begin
                        short_err = 1'b1;
                        state_d   = H0;
                    end else begin
                        state_d = H1;
                    end
                end
                H1: begin
                    if (bus.last_i) begin
                        short_err = 1'b1;
                        state_d   = H0;
                    end else begin
                        state_d = H2;
                    end
                end
                H2: begin
                    do_lock = !sess_lock_q;
                    if (!sess_ok) begin
                        reject   = 1'b1;
                        mismatch = 1'b1;
                    end else if (pkt_cnt == 16'hFFFF) begin
                        accept = 1'b1;
                        is_eos = 1'b1;
                    end else if (pkt_seq == exp_eff) begin
                        accept = 1'b1;
                    end else if (pkt_seq < exp_eff) begin
                        reject = 1'b1;
                        is_dup = 1'b1;
                    end else begin
                        reject = 1'b1;
                        is_gap = 1'b1;
                    end
                    fwd_beat = accept && (pkt_cnt != 16'h0000) && (pkt_cnt != 16'hFFFF);
                    if (fwd_beat && !bus.last_i)    state_d = FWD;
                    else if (reject && !bus.last_i) state_d = DROP;
                    else                            state_d = H0;
                end
                FWD: begin
                    fwd_beat = 1'b1;
                    if (bus.last_i) state_d = H0;
                end
                DROP: begin
                    if (bus.last_i) state_d = H0;
                end
                default: state_d = H0;
            endcase
        end
    end

    // Header capture, session lock, expected sequence and end-of-session
    always_ff @(posedge clk) begin
        if (!nreset) begin
            sess_hi_q   <= '0;
            sess_lo_q   <= '0;
            seq_hi_q    <= '0;
            sess_q      <= '0;
            sess_lock_q <= 1'b0;
            exp_seq_q   <= '0;
            eos_q       <= 1'b0;
        end else if (bus.valid_i) begin
            if (state_q == H0) sess_hi_q <= beat_be;
            if (state_q == H1) begin
                sess_lo_q <= beat_be[63:48];
                seq_hi_q  <= beat_be[47:0];
            end
            if (do_lock) begin
                sess_q      <= pkt_sess;
                sess_lock_q <= 1'b1;
            end
            // End of session keeps the expected value; in-order data advances it.
            if (accept) exp_seq_q <= is_eos ? exp_eff : pkt_seq + {48'd0, pkt_cnt};
            if (is_eos) eos_q <= 1'b1;
        end
    end

    // Retransmit request: open, merge into a pending one, or retire on ready
    always_ff @(posedge clk) begin
        if (!nreset) begin
            rtx_valid_q <= 1'b0;
            rtx_seq_q   <= '0;
            rtx_cnt_q   <= '0;
        end else if (is_gap) begin
            rtx_valid_q <= 1'b1;
            if (rtx_valid_q && !bus.rtx_ready_i) begin
                rtx_cnt_q <= sat16(pkt_seq - rtx_seq_q);
            end else begin
                rtx_seq_q <= exp_seq_q;
                rtx_cnt_q <= sat16(pkt_seq - exp_seq_q);
            end
        end else if (bus.rtx_ready_i) begin
            rtx_valid_q <= 1'b0;
        end
    end

    // Dispatcher beat register and event pulses, one cycle behind the input
    always_ff @(posedge clk) begin
        if (!nreset) begin
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
            disp_keep_q  <= '0;
            disp_init_q  <= 1'b0;
            disp_last_q  <= 1'b0;
            drop_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            disp_valid_q <= fwd_beat;
            disp_init_q  <= fwd_beat && (state_q == H2);
            disp_last_q  <= fwd_beat && bus.last_i;
            if (fwd_beat) begin
                disp_data_q <= bus.data_i;
                disp_keep_q <= bus.keep_i;
            end
            drop_q <= is_dup || is_gap;
            err_q  <= short_err || mismatch;
        end
    end

`ifdef MOLD_SEQ_STATS_EN
    logic [31:0] stat_acc_q;
    logic [31:0] stat_drop_q;
    logic [31:0] stat_gap_q;

    // Saturating packet counters
    always_ff @(posedge clk) begin
        if (!nreset) begin
            stat_acc_q  <= '0;
            stat_drop_q <= '0;
            stat_gap_q  <= '0;
        end else begin
            if (accept && stat_acc_q != 32'hFFFF_FFFF)                  stat_acc_q  <= stat_acc_q + 32'd1;
            if ((is_dup || is_gap) && stat_drop_q != 32'hFFFF_FFFF)     stat_drop_q <= stat_drop_q + 32'd1;
            if (is_gap && stat_gap_q != 32'hFFFF_FFFF)                  stat_gap_q  <= stat_gap_q + 32'd1;
        end
    end

    assign stat_acc_o  = stat_acc_q;
    assign stat_drop_o = stat_drop_q;
    assign stat_gap_o  = stat_gap_q;
`endif

    assign bus.disp_valid_o  = disp_valid_q;
    assign bus.disp_data_o   = disp_data_q;
    assign bus.disp_keep_o   = disp_keep_q;
    assign bus.disp_init_v_o = disp_init_q;
    assign bus.disp_last_o   = disp_last_q;
    assign bus.rtx_valid_o   = rtx_valid_q;
    assign bus.rtx_seq_o     = rtx_seq_q;
    assign bus.rtx_cnt_o     = rtx_cnt_q;
    assign exp_seq_o         = exp_seq_q;
    assign sess_lock_o       = sess_lock_q;
    assign eos_o             = eos_q;
    assign drop_o            = drop_q;
    assign err_o             = err_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_moldudp64_seq_ctrl.sv
// Directed bench for moldudp64_seq_ctrl: packets are built byte by byte,
// expected dispatcher beats and drop/err events go into queues, and monitors
// pop them whenever the controller presents an output.
`timescale 1ns/1ps
module tb_moldudp64_seq_ctrl;

    // Clock and reset
    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    moldudp64_seq_ctrl_if bus ();

    logic [63:0] exp_seq_o;
    logic        sess_lock_o;
    logic        eos_o;
    logic        drop_o;
    logic        err_o;
    logic [2:0]  state_o;
`ifdef MOLD_SEQ_STATS_EN
    logic [31:0] stat_acc_o;
    logic [31:0] stat_drop_o;
    logic [31:0] stat_gap_o;
`endif

    moldudp64_seq_ctrl dut (
        .clk         (clk),
        .nreset      (nreset),
        .bus         (bus),
        .exp_seq_o   (exp_seq_o),
        .sess_lock_o (sess_lock_o),
        .eos_o       (eos_o),
        .drop_o      (drop_o),
        .err_o       (err_o),
        .state_o     (state_o)
`ifdef MOLD_SEQ_STATS_EN
        ,
        .stat_acc_o  (stat_acc_o),
        .stat_drop_o (stat_drop_o),
        .stat_gap_o  (stat_gap_o)
`endif
    );

    localparam logic [79:0] SESS_A = 80'h4142_4344_4546_4748_494A; // "ABCDEFGHIJ"
    localparam logic [79:0] SESS_Z = 80'h5A5A_5A5A_5A5A_5A5A_5A5A; // "ZZZZZZZZZZ"
    localparam logic [1:0]  EV_NONE = 2'b00;
    localparam logic [1:0]  EV_DROP = 2'b01;
    localparam logic [1:0]  EV_ERR  = 2'b10;

    // Scoreboard: {init, last, keep, data} per forwarded beat; {err, drop} per event
    int n_chk  = 0;
    int n_pass = 0;
    logic [73:0] exp_q[$];
    logic [1:0]  ev_q[$];
    logic [73:0] mon_beat;
    logic [1:0]  mon_ev;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Dispatcher monitor
    always @(negedge clk) begin
        if (bus.disp_valid_o) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL disp_unexpected: got beat 0x%0h, expected no beat", bus.disp_data_o);
            end else begin
                mon_beat = exp_q.pop_front();
                chk("disp_beat",
                    {6'd0, bus.disp_init_v_o, bus.disp_last_o, bus.disp_keep_o, bus.disp_data_o},
                    {6'd0, mon_beat});
            end
        end
    end

    // Drop/err pulse monitor
    always @(negedge clk) begin
        if (drop_o || err_o) begin
            if (ev_q.size() == 0) begin
                n_chk++;
                $display("FAIL event_unexpected: got err=%0d drop=%0d, expected none", err_o, drop_o);
            end else begin
                mon_ev = ev_q.pop_front();
                chk("event", {78'd0, err_o, drop_o}, {78'd0, mon_ev});
            end
        end
    end

    // Driver: one packet of len bytes; stop_at truncates after that many beats
    task automatic send_pkt(input logic [79:0] sess, input logic [63:0] seq, input logic [15:0] cnt,
                            input int len, input bit fwd, input logic [1:0] ev,
                            input bit rdy_b2, input int stop_at);
        logic [7:0]  b [0:63];
        logic [63:0] d;
        logic [7:0]  k;
        int          nb;
        nb = (len + 7) / 8;
        for (int i = 0; i < 64; i++) b[i] = 8'(i * 7 + 49);
        for (int i = 0; i < 10; i++) b[i] = sess[79-8*i -: 8];
        for (int i = 0; i < 8; i++)  b[10+i] = seq[63-8*i -: 8];
        b[18] = cnt[15:8];
        b[19] = cnt[7:0];
        if (ev != EV_NONE) ev_q.push_back(ev);
        for (int bt = 0; bt < nb && bt < stop_at; bt++) begin
            for (int j = 0; j < 8; j++) begin
                d[8*j +: 8] = b[8*bt+j];
                k[j]        = (8*bt + j < len);
            end
            if (fwd && bt >= 2) exp_q.push_back({bt == 2, bt == nb - 1, k, d});
            bus.valid_i     = 1'b1;
            bus.data_i      = d;
            bus.keep_i      = k;
            bus.last_i      = (bt == nb - 1);
            bus.rtx_ready_i = rdy_b2 && (bt == 2);
            @(posedge clk); #1;
        end
        bus.valid_i     = 1'b0;
        bus.last_i      = 1'b0;
        bus.rtx_ready_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        bus.valid_i     = 1'b0;
        bus.data_i      = '0;
        bus.keep_i      = '0;
        bus.last_i      = 1'b0;
        bus.rtx_ready_i = 1'b0;
        nreset          = 1'b0;
        idle(3);

        // Reset state
        chk("rst_disp_valid", 80'(bus.disp_valid_o), 80'd0);
        chk("rst_exp_seq",    80'(exp_seq_o),        80'd0);
        chk("rst_sess_lock",  80'(sess_lock_o),      80'd0);
        chk("rst_eos",        80'(eos_o),            80'd0);
        chk("rst_rtx_valid",  80'(bus.rtx_valid_o),  80'd0);
        chk("rst_rtx_seq",    80'(bus.rtx_seq_o),    80'd0);
        chk("rst_rtx_cnt",    80'(bus.rtx_cnt_o),    80'd0);
        chk("rst_state",      80'(state_o),          80'd0);
        nreset = 1'b1;
        idle(1);

        // Lock and forward: seq 0x10 cnt 3, 5 beats
        send_pkt(SESS_A, 64'h10, 16'd3, 40, 1'b1, EV_NONE, 1'b0, 99);
        chk("lock_sess_lock", 80'(sess_lock_o), 80'd1);
        chk("lock_exp_seq",   80'(exp_seq_o),   80'h13);

        // Gap: seq 0x20 cnt 2
        send_pkt(SESS_A, 64'h20, 16'd2, 32, 1'b0, EV_DROP, 1'b0, 99);
        chk("gap_rtx_valid", 80'(bus.rtx_valid_o), 80'd1);
        chk("gap_rtx_seq",   80'(bus.rtx_seq_o),   80'h13);
        chk("gap_rtx_cnt",   80'(bus.rtx_cnt_o),   80'h0D);
        chk("gap_exp_seq",   80'(exp_seq_o),       80'h13);
        idle(3);
        chk("gap_rtx_hold",  80'(bus.rtx_valid_o), 80'd1);

        // Merge while pending: seq 0x30
        send_pkt(SESS_A, 64'h30, 16'd1, 24, 1'b0, EV_DROP, 1'b0, 99);
        chk("merge_rtx_seq", 80'(bus.rtx_seq_o), 80'h13);
        chk("merge_rtx_cnt", 80'(bus.rtx_cnt_o), 80'h1D);
        bus.rtx_ready_i = 1'b1;
        idle(1);
        bus.rtx_ready_i = 1'b0;
        chk("merge_rtx_done", 80'(bus.rtx_valid_o), 80'd0);

        // Duplicate: seq 0x10
        send_pkt(SESS_A, 64'h10, 16'd1, 24, 1'b0, EV_DROP, 1'b0, 99);
        chk("dup_exp_seq",   80'(exp_seq_o),       80'h13);
        chk("dup_rtx_valid", 80'(bus.rtx_valid_o), 80'd0);

        // Wrong session
        send_pkt(SESS_Z, 64'h13, 16'd1, 32, 1'b0, EV_ERR, 1'b0, 99);
        chk("sess_exp_seq", 80'(exp_seq_o), 80'h13);

        // Heartbeat: cnt 0, 20 bytes
        send_pkt(SESS_A, 64'h13, 16'd0, 20, 1'b0, EV_NONE, 1'b0, 99);
        chk("hb_exp_seq", 80'(exp_seq_o), 80'h13);
        chk("hb_eos",     80'(eos_o),     80'd0);

        // Single forwarded beat (init+last on beat 2)
        send_pkt(SESS_A, 64'h13, 16'd1, 24, 1'b1, EV_NONE, 1'b0, 99);
        chk("single_exp_seq", 80'(exp_seq_o), 80'h14);

        // Saturated gap count
        send_pkt(SESS_A, 64'h10_0000, 16'd1, 24, 1'b0, EV_DROP, 1'b0, 99);
        chk("sat_rtx_seq", 80'(bus.rtx_seq_o), 80'h14);
        chk("sat_rtx_cnt", 80'(bus.rtx_cnt_o), 80'hFFFF);

        // In-order while a request is pending
        send_pkt(SESS_A, 64'h14, 16'd2, 40, 1'b1, EV_NONE, 1'b0, 99);
        chk("pend_exp_seq",   80'(exp_seq_o),       80'h16);
        chk("pend_rtx_valid", 80'(bus.rtx_valid_o), 80'd1);

        // Gap in the same cycle as ready opens a fresh request
        send_pkt(SESS_A, 64'h20, 16'd1, 24, 1'b0, EV_DROP, 1'b1, 99);
        chk("renew_rtx_valid", 80'(bus.rtx_valid_o), 80'd1);
        chk("renew_rtx_seq",   80'(bus.rtx_seq_o),   80'h16);
        chk("renew_rtx_cnt",   80'(bus.rtx_cnt_o),   80'h0A);
        bus.rtx_ready_i = 1'b1;
        idle(1);
        bus.rtx_ready_i = 1'b0;
        chk("renew_rtx_done", 80'(bus.rtx_valid_o), 80'd0);

        // End of session, then sticky across a heartbeat
        send_pkt(SESS_A, 64'h16, 16'hFFFF, 20, 1'b0, EV_NONE, 1'b0, 99);
        chk("eos_set",     80'(eos_o),     80'd1);
        chk("eos_exp_seq", 80'(exp_seq_o), 80'h16);
        send_pkt(SESS_A, 64'h16, 16'd0, 20, 1'b0, EV_NONE, 1'b0, 99);
        chk("eos_sticky",  80'(eos_o),     80'd1);

        // Short packet (last on beat 1), then a normal packet parses from H0
        send_pkt(SESS_A, 64'h16, 16'd1, 16, 1'b0, EV_ERR, 1'b0, 99);
        chk("short_state",   80'(state_o),   80'd0);
        chk("short_exp_seq", 80'(exp_seq_o), 80'h16);
        send_pkt(SESS_A, 64'h16, 16'd1, 24, 1'b1, EV_NONE, 1'b0, 99);
        chk("after_short_exp_seq", 80'(exp_seq_o), 80'h17);

        // Reset in the middle of a forwarded packet
        send_pkt(SESS_A, 64'h17, 16'd2, 48, 1'b1, EV_NONE, 1'b0, 4);
        chk("mid_state_fwd", 80'(state_o), 80'd3);
        nreset = 1'b0;
        idle(1);
        chk("mrst_disp_valid", 80'(bus.disp_valid_o), 80'd0);
        chk("mrst_sess_lock",  80'(sess_lock_o),      80'd0);
        chk("mrst_exp_seq",    80'(exp_seq_o),        80'd0);
        chk("mrst_eos",        80'(eos_o),            80'd0);
        chk("mrst_state",      80'(state_o),          80'd0);
        nreset = 1'b1;
        idle(1);

        // Relock after reset
        send_pkt(SESS_A, 64'h50, 16'd1, 24, 1'b1, EV_NONE, 1'b0, 99);
        chk("relock_sess_lock", 80'(sess_lock_o), 80'd1);
        chk("relock_exp_seq",   80'(exp_seq_o),   80'h51);
`ifdef MOLD_SEQ_STATS_EN
        chk("stat_acc",  80'(stat_acc_o),  80'd1);
        chk("stat_drop", 80'(stat_drop_o), 80'd0);
        chk("stat_gap",  80'(stat_gap_o),  80'd0);
`endif

        idle(3);
        chk("beats_left",  80'(exp_q.size()), 80'd0);
        chk("events_left", 80'(ev_q.size()),  80'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
